dmem_responder: RTL

//  Memory-side responder for the core's data-memory request interface.

---
 rtl/dmem_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: ready/valid request port, WAIT_STATES cycles of latency,
// byte/half/word access to a word-organised array with alignment and range faults.

package dmem_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_t;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_req,
    input  logic        dmem_wr_en,
    input  mem_size_t   dmem_size,
    input  logic        dmem_zero_extend,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wr_data,
    output logic        dmem_ready,
    output logic        dmem_rvalid,
    output logic [31:0] dmem_rd_data,
    output logic        dmem_err
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        wr_en_q, wr_en_d;
    mem_size_t   size_q, size_d;
    logic        zx_q, zx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        t_wr, t_zx, t_misaligned, t_fault;
    mem_size_t   t_size;
    logic [31:0] t_addr, t_word, t_load;
    logic [7:0]  t_byte;
    logic [15:0] t_half;
    logic [3:0]  be;
    logic [31:0] wlanes;
    logic        commit;

    // The transaction entering RESP comes straight off the bus when WAIT_STATES=0.
    always_comb begin
        t_wr   = (state_q == IDLE) ? dmem_wr_en       : wr_en_q;
        t_size = (state_q == IDLE) ? dmem_size        : size_q;
        t_zx   = (state_q == IDLE) ? dmem_zero_extend : zx_q;
        t_addr = (state_q == IDLE) ? dmem_addr        : addr_q;

        case (t_size)
            SZ_BYTE: t_misaligned = 1'b0;
            SZ_HALF: t_misaligned = t_addr[0];
            SZ_WORD: t_misaligned = |t_addr[1:0];
            default: t_misaligned = 1'b1;
        endcase
        t_fault = t_misaligned || ({1'b0, t_addr} >= ADDR_LIMIT);

        t_word = mem[t_addr[IDX_W+1:2]];
        case (t_addr[1:0])
            2'd0:    t_byte = t_word[7:0];
            2'd1:    t_byte = t_word[15:8];
            2'd2:    t_byte = t_word[23:16];
            default: t_byte = t_word[31:24];
        endcase
        t_half = t_addr[1] ? t_word[31:16] : t_word[15:0];

        case (t_size)
            SZ_BYTE: t_load = t_zx ? {24'd0, t_byte} : {{24{t_byte[7]}}, t_byte};
            SZ_HALF: t_load = t_zx ? {16'd0, t_half} : {{16{t_half[15]}}, t_half};
            default: t_load = t_word;
        endcase
    end

    always_comb begin
        accept     = dmem_req && ready_q && (state_q == IDLE);
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_en_d    = wr_en_q;
        size_d     = size_q;
        zx_d       = zx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        rd_data_d  = 32'd0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_en_d = dmem_wr_en;
                    size_d  = dmem_size;
                    zx_d    = dmem_zero_extend;
                    addr_d  = dmem_addr;
                    wdata_d = dmem_wr_data;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = RESP;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        if (state_d == RESP && state_q != RESP) begin
            rvalid_d  = 1'b1;
            err_d     = t_fault;
            rd_data_d = (t_fault || t_wr) ? 32'd0 : t_load;
        end
    end

    // Store lanes come from the latched request; reset suppresses the RESP-edge write.
    always_comb begin
        case (size_q)
            SZ_BYTE: begin
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = wdata_q;
            end
        endcase
        commit = reset_n && (state_q == RESP) && wr_en_q && !err_q;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[IDX_W+1:2]][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            wr_en_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            zx_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_en_q    <= wr_en_d;
            size_q     <= size_d;
            zx_q       <= zx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign dmem_ready   = ready_q;
    assign dmem_rvalid  = rvalid_q;
    assign dmem_rd_data = rd_data_q;
    assign dmem_err     = err_q;

endmodule
